sdram_host_arbiter: RTL

- Shares the single host port of `sdram_controller_silica` between NUM_REQ requesters in the 100 MHz domain, for example a FIFO-fed debug port and a DMA/video port.
- Grants requesters round-robin and issues one command at a time, using single-cycle enable pulses paced by the controller `busy` signal.
- Tracks read ownership and routes `rd_data` back to the requester that issued the read.
- Sits between the cross-clock FIFOs' 100 MHz side and the SDRAM controller.

---
 rtl/sdram_arb_pkg.sv | 23 ++
 rtl/sdram_host_arbiter_rr_pick.sv | 25 ++
 rtl/sdram_host_arbiter.sv | 117 +++++++++++
 3 files changed

// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg: shared state encoding and width helpers for the SDRAM host arbiter
package sdram_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_ACCEPT,
        WAIT_WDONE,
        WAIT_RDATA,
        WAIT_RDONE
    } state_t;

    localparam int DEF_ACCEPT_TIMEOUT = 15;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_width(input int t);
        return (t > 1) ? $clog2(t) : 1;
    endfunction

endpackage

// File: rtl/sdram_host_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector, first valid index after ptr with wrap
module rr_pick
    import sdram_arb_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = idx_width(N)
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] ptr,
    output logic          found,
    output logic [IW-1:0] idx
);

    assign found = |valid;

    // indices above ptr beat the wrapped ones; within each group the lowest wins
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--)
            if (valid[i] && IW'(i) <= ptr) idx = IW'(i);
        for (int i = N - 1; i >= 0; i--)
            if (valid[i] && IW'(i) > ptr) idx = IW'(i);
    end

endmodule

// File: rtl/sdram_host_arbiter.sv
// sdram_host_arbiter: round-robin sharing of the SDRAM controller host port between requesters
module sdram_host_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int HADDR_WIDTH    = 24,
    parameter int DATA_WIDTH     = 16,
    parameter int ACCEPT_TIMEOUT = DEF_ACCEPT_TIMEOUT
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ*HADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            req_ack,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic [HADDR_WIDTH-1:0]        ctrl_wr_addr,
    output logic [DATA_WIDTH-1:0]         ctrl_wr_data,
    output logic                          ctrl_wr_enable,
    output logic [HADDR_WIDTH-1:0]        ctrl_rd_addr,
    output logic                          ctrl_rd_enable,
    input  logic [DATA_WIDTH-1:0]         ctrl_rd_data,
    input  logic                          ctrl_rd_ready,
    input  logic                          ctrl_busy
);

    localparam int IW = idx_width(NUM_REQ);
    localparam int CW = cnt_width(ACCEPT_TIMEOUT);

    state_t                 state, state_nx;
    logic [IW-1:0]          ptr, idx, pick_idx;
    logic                   pick_found;
    logic                   we_q;
    logic [HADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0]  wdata_q;
    logic [CW-1:0]          cnt, cnt_nx;
    logic                   grant, accept, capture;
    logic [NUM_REQ-1:0]     idx_hot;

    rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
        .valid (req_valid),
        .ptr   (ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign idx_hot        = NUM_REQ'(1) << idx;
    assign ctrl_wr_enable = (state == ISSUE) && we_q;
    assign ctrl_rd_enable = (state == ISSUE) && !we_q;
    assign ctrl_wr_addr   = addr_q;
    assign ctrl_rd_addr   = addr_q;
    assign ctrl_wr_data   = wdata_q;

    // next-state and per-cycle event decode; the enable pulse is the single ISSUE cycle
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        grant    = 1'b0;
        accept   = 1'b0;
        capture  = 1'b0;
        case (state)
            IDLE: if (pick_found && !ctrl_busy) begin
                grant    = 1'b1;
                state_nx = ISSUE;
            end
            ISSUE: begin
                cnt_nx   = '0;
                state_nx = WAIT_ACCEPT;
            end
            WAIT_ACCEPT: if (ctrl_busy) begin
                accept   = 1'b1;
                state_nx = we_q ? WAIT_WDONE : WAIT_RDATA;
            end else begin
                cnt_nx   = cnt + 1'b1;
                state_nx = (cnt == CW'(ACCEPT_TIMEOUT - 1)) ? ISSUE : WAIT_ACCEPT;
            end
            WAIT_WDONE, WAIT_RDONE: state_nx = ctrl_busy ? state : IDLE;
            WAIT_RDATA: if (ctrl_rd_ready) begin
                capture  = 1'b1;
                state_nx = ctrl_busy ? WAIT_RDONE : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // state, latched command and registered handshake outputs; reset abandons any command
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            ptr       <= IW'(NUM_REQ - 1);
            idx       <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            req_ack   <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            req_ack   <= (accept && req_valid[idx]) ? idx_hot : '0;
            rsp_valid <= capture ? idx_hot : '0;
            if (capture) rsp_data <= ctrl_rd_data;
            if (grant) begin
                ptr     <= pick_idx;
                idx     <= pick_idx;
                we_q    <= req_we[pick_idx];
                addr_q  <= req_addr[pick_idx*HADDR_WIDTH +: HADDR_WIDTH];
                wdata_q <= req_wdata[pick_idx*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

endmodule
